// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : imem_loader
//  Purpose  : Write-side filler for the 8 x 16-bit instruction memory. Takes
//             a byte stream over valid/ready, pairs hi/lo bytes into words,
//             writes them to addresses 0..DEPTH-1, then compares a trailing
//             XOR checksum byte. Holds the CPU stalled for the whole load.
//  Ports    : clk, rst_n        - clock, asynchronous active-low reset
//             start             - one-cycle pulse, begins a session from IDLE
//             byte_in/valid     - incoming stream byte and its qualifier
//             byte_ready        - loader accepts byte_in this cycle
//             wr_en/addr/data   - instruction-memory write port
//             busy, cpu_hold    - session in progress / CPU stall request
//             done              - one-cycle end-of-session pulse
//             chk_err           - sticky checksum-mismatch flag
//  Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3,
   parameter int DEPTH  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              busy,
   output logic              cpu_hold,
   output logic              done,
   output logic              chk_err
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_HI   = 3'd1,
      S_LO   = 3'd2,
      S_WR   = 3'd3,
      S_CHK  = 3'd4,
      S_FIN  = 3'd5
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t            state;
   state_t            state_nxt;
   logic [7:0]        hi_byte;
   logic [7:0]        acc;
   logic [ADDR_W-1:0] cnt;
   logic              xfer;

   // byte_ready is decoded from the state register only, so a transfer is
   // never combinationally dependent on byte_valid looping back.
   assign xfer = byte_valid && byte_ready;

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ------------------------------------------------- next state / outputs
   always_comb begin
      state_nxt  = state;
      byte_ready = 1'b0;
      wr_en      = 1'b0;
      busy       = 1'b0;
      cpu_hold   = 1'b0;
      done       = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_nxt = S_HI;
         end
         S_HI: begin
            byte_ready = 1'b1;
            busy       = 1'b1;
            cpu_hold   = 1'b1;
            if (byte_valid) state_nxt = S_LO;
         end
         S_LO: begin
            byte_ready = 1'b1;
            busy       = 1'b1;
            cpu_hold   = 1'b1;
            if (byte_valid) state_nxt = S_WR;
         end
         S_WR: begin
            wr_en    = 1'b1;
            busy     = 1'b1;
            cpu_hold = 1'b1;
            state_nxt = (cnt == LAST_ADDR) ? S_CHK : S_HI;
         end
         S_CHK: begin
            byte_ready = 1'b1;
            busy       = 1'b1;
            cpu_hold   = 1'b1;
            if (byte_valid) state_nxt = S_FIN;
         end
         S_FIN: begin
            // start is deliberately not looked at here; only IDLE honours it
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_byte <= 8'h00;
         acc     <= 8'h00;
         cnt     <= '0;
         wr_addr <= '0;
         wr_data <= '0;
         chk_err <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  cnt     <= '0;
                  acc     <= 8'h00;
                  chk_err <= 1'b0;
               end
            end
            S_HI: begin
               if (xfer) begin
                  hi_byte <= byte_in;
                  acc     <= acc ^ byte_in;
               end
            end
            S_LO: begin
               // Address and data are captured together so they are stable
               // for the whole WR cycle.
               if (xfer) begin
                  wr_data <= {hi_byte, byte_in};
                  wr_addr <= cnt;
                  acc     <= acc ^ byte_in;
               end
            end
            S_WR: begin
               // Explicit last-address compare keeps cnt from wrapping.
               if (cnt != LAST_ADDR) cnt <= cnt + ADDR_W'(1);
            end
            S_CHK: begin
               if (xfer) chk_err <= (byte_in != acc);
            end
            default: begin
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_loader
//  Purpose  : Self-checking bench for imem_loader. Expected writes are pushed
//             to a scoreboard queue as each low byte is driven and popped by
//             a monitor whenever wr_en is seen.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_ready;
   logic        wr_en;
   logic [2:0]  wr_addr;
   logic [15:0] wr_data;
   logic        busy;
   logic        cpu_hold;
   logic        done;
   logic        chk_err;

   imem_loader #(.DATA_W(16), .ADDR_W(3), .DEPTH(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .busy       (busy),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .chk_err    (chk_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int wr_cnt = 0;
   int done_cnt = 0;

   logic [18:0] exp_q[$];          // {addr, data}
   logic [15:0] words [8];

   // ------------------------------------------------------------ monitor
   always @(negedge clk) begin
      if (done) done_cnt++;
      if (wr_en) begin
         logic [18:0] e;
         wr_cnt++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL write_unexpected: got addr=%0d data=%h, expected no write", wr_addr, wr_data);
         end else begin
            e = exp_q.pop_front();
            if ({wr_addr, wr_data} !== e) begin
               errors++;
               $display("FAIL write_data: got addr=%0d data=%h, expected addr=%0d data=%h",
                        wr_addr, wr_data, e[18:16], e[15:0]);
            end
         end
         checks++;
         if (byte_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_in_wr: got byte_ready=%b, expected 0", byte_ready);
         end
      end
   end

   // ------------------------------------------------------------ drivers
   task automatic send_byte(input logic [7:0] b, input bit throttle);
      bit sent = 0;
      if (throttle) begin
         byte_valid = 1'b0;
         @(posedge clk); #1;
      end
      byte_valid = 1'b1;
      byte_in    = b;
      for (int g = 0; g < 50; g++) begin
         @(negedge clk);
         if (byte_ready) begin
            @(posedge clk); #1;
            sent = 1;
            break;
         end
      end
      byte_valid = 1'b0;
      if (!sent) begin
         checks++;
         errors++;
         $display("FAIL byte_timeout: byte %h not accepted within 50 cycles, expected acceptance", b);
      end
   endtask

   task automatic send_word(input int idx, input bit throttle);
      send_byte(words[idx][15:8], throttle);
      exp_q.push_back({3'(idx), words[idx]});
      send_byte(words[idx][7:0], throttle);
   endtask

   task automatic run_session(input bit throttle, input bit bad);
      logic [7:0] x = 8'h00;
      for (int i = 0; i < 8; i++) begin
         x = x ^ words[i][15:8] ^ words[i][7:0];
         send_word(i, throttle);
      end
      send_byte(bad ? (x ^ 8'h01) : x, throttle);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Counts cycles after the start edge until done is seen.
   task automatic watch_done(input bit poke_start, output int n,
                             output bit hold_ok, output bit released);
      bit poked = 0;
      n = 0;
      hold_ok = 1;
      released = 0;
      for (int i = 1; i <= 400; i++) begin
         @(negedge clk);
         if (done) begin
            n = i;
            released = (cpu_hold === 1'b0) && (busy === 1'b0);
            break;
         end
         if (cpu_hold !== 1'b1 || busy !== 1'b1) hold_ok = 0;
         if (poke_start && !poked && wr_cnt == 5) begin
            poked = 1;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
         end
      end
   endtask

   // -------------------------------------------------------------- tests
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({byte_ready, wr_en, busy, cpu_hold, done, chk_err} !== 6'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b, expected 000000",
                  {byte_ready, wr_en, busy, cpu_hold, done, chk_err});
      end
      checks++;
      if ({wr_addr, wr_data} !== 19'h0) begin
         errors++;
         $display("FAIL reset_bus: got addr=%0d data=%h, expected 0/0000", wr_addr, wr_data);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({byte_ready, busy, cpu_hold} !== 3'b0) begin
         errors++;
         $display("FAIL post_reset_idle: got %b, expected 000", {byte_ready, busy, cpu_hold});
      end
   endtask

   task automatic test_idle_noise();
      wr_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         byte_valid = 1'b1;
         byte_in    = 8'($urandom);
         @(negedge clk);
         checks++;
         if ({byte_ready, wr_en, busy} !== 3'b000) begin
            errors++;
            $display("FAIL idle_noise: got ready/wr_en/busy=%b, expected 000",
                     {byte_ready, wr_en, busy});
         end
         @(posedge clk); #1;
      end
      byte_valid = 1'b0;
      checks++;
      if (wr_cnt !== 0) begin
         errors++;
         $display("FAIL idle_writes: got %0d writes, expected 0", wr_cnt);
      end
   endtask

   task automatic test_nominal();
      int n; bit hold_ok; bit rel;
      wr_cnt = 0;
      pulse_start();
      fork
         run_session(1'b0, 1'b0);
         watch_done(1'b0, n, hold_ok, rel);
      join
      checks++;
      if (n !== 26) begin
         errors++;
         $display("FAIL nominal_latency: got done at cycle %0d, expected 26", n);
      end
      checks++;
      if (!hold_ok || !rel) begin
         errors++;
         $display("FAIL nominal_hold: got hold_ok=%b released=%b, expected 1/1", hold_ok, rel);
      end
      checks++;
      if (chk_err !== 1'b0) begin
         errors++;
         $display("FAIL nominal_chk: got chk_err=%b, expected 0", chk_err);
      end
      @(posedge clk); #1;
      checks++;
      if (wr_cnt !== 8 || exp_q.size() !== 0) begin
         errors++;
         $display("FAIL nominal_writes: got %0d writes, %0d pending, expected 8/0", wr_cnt, exp_q.size());
      end
   endtask

   task automatic test_bad_checksum();
      int n; bit hold_ok; bit rel;
      wr_cnt = 0;
      pulse_start();
      fork
         run_session(1'b0, 1'b1);
         watch_done(1'b0, n, hold_ok, rel);
      join
      checks++;
      if (chk_err !== 1'b1 || !rel) begin
         errors++;
         $display("FAIL bad_chk_done: got chk_err=%b released=%b, expected 1/1", chk_err, rel);
      end
      @(posedge clk); #1;
      repeat (5) begin @(posedge clk); #1; end
      checks++;
      if (chk_err !== 1'b1 || wr_cnt !== 8) begin
         errors++;
         $display("FAIL bad_chk_sticky: got chk_err=%b writes=%0d, expected 1/8", chk_err, wr_cnt);
      end
      wr_cnt = 0;
      pulse_start();
      checks++;
      if (chk_err !== 1'b0) begin
         errors++;
         $display("FAIL bad_chk_clear: got chk_err=%b after start, expected 0", chk_err);
      end
      fork
         run_session(1'b0, 1'b0);
         watch_done(1'b0, n, hold_ok, rel);
      join
      checks++;
      if (chk_err !== 1'b0 || n !== 26) begin
         errors++;
         $display("FAIL reload_clean: got chk_err=%b cycles=%0d, expected 0/26", chk_err, n);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_throttled();
      int n; bit hold_ok; bit rel;
      wr_cnt = 0;
      pulse_start();
      fork
         run_session(1'b1, 1'b0);
         watch_done(1'b0, n, hold_ok, rel);
      join
      checks++;
      if (n <= 26 || !hold_ok || chk_err !== 1'b0) begin
         errors++;
         $display("FAIL throttled_session: got cycles=%0d hold_ok=%b chk_err=%b, expected >26/1/0",
                  n, hold_ok, chk_err);
      end
      @(posedge clk); #1;
      checks++;
      if (wr_cnt !== 8 || exp_q.size() !== 0) begin
         errors++;
         $display("FAIL throttled_writes: got %0d writes, %0d pending, expected 8/0", wr_cnt, exp_q.size());
      end
   endtask

   task automatic test_start_during();
      int n; bit hold_ok; bit rel;
      wr_cnt = 0;
      done_cnt = 0;
      pulse_start();
      fork
         run_session(1'b0, 1'b0);
         watch_done(1'b1, n, hold_ok, rel);
      join
      @(posedge clk); #1;
      repeat (3) begin @(posedge clk); #1; end
      checks++;
      if (n !== 26 || done_cnt !== 1) begin
         errors++;
         $display("FAIL start_during: got cycles=%0d done_pulses=%0d, expected 26/1", n, done_cnt);
      end
      checks++;
      if (wr_cnt !== 8 || exp_q.size() !== 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL start_during_writes: got writes=%0d pending=%0d busy=%b, expected 8/0/0",
                  wr_cnt, exp_q.size(), busy);
      end
   endtask

   task automatic test_reset_mid_word();
      wr_cnt = 0;
      pulse_start();
      for (int i = 0; i < 3; i++) send_word(i, 1'b0);
      send_byte(words[3][15:8], 1'b0);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({byte_ready, wr_en, busy, cpu_hold, done, chk_err} !== 6'b0 ||
          {wr_addr, wr_data} !== 19'h0) begin
         errors++;
         $display("FAIL reset_async: got flags=%b addr=%0d data=%h, expected all 0",
                  {byte_ready, wr_en, busy, cpu_hold, done, chk_err}, wr_addr, wr_data);
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (5) begin @(posedge clk); #1; end
      checks++;
      if (wr_cnt !== 3 || exp_q.size() !== 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_word: got writes=%0d pending=%0d busy=%b, expected 3/0/0",
                  wr_cnt, exp_q.size(), busy);
      end
   endtask

   initial begin
      words[0] = 16'h0210; words[1] = 16'h0211;
      words[2] = 16'h0212; words[3] = 16'h0213;
      words[4] = 16'h2214; words[5] = 16'hEFDF;
      words[6] = 16'h0000; words[7] = 16'h0000;
      rst_n = 1'b0;
      start = 1'b0;
      byte_in = 8'h00;
      byte_valid = 1'b0;
      #2;
      test_reset();
      test_idle_noise();
      test_nominal();
      test_bad_checksum();
      test_throttled();
      test_start_during();
      test_reset_mid_word();
      test_idle_noise();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
